fe_arbiter: RTL

FE_ARBITER -- requirements
Module: fe_arbiter

---
 rtl/fe_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fe_arbiter.sv
// fe_arbiter: round-robin arbiter that picks one MAC port per cycle and
// hands its packet descriptor (port, length, first 32 header bytes) to the
// forwarding engine through a single-entry output register.
// Optional feature macro: FE_ARB_LEN_CHECK_EN (drop runt/oversize packets
// and count them in drop_cnt). Without it every length is forwarded.
module fe_arbiter #(
  parameter int NPORTS = 4,
  parameter int PW     = $clog2(NPORTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NPORTS-1:0]     arb_valid,
  input  logic [NPORTS*12-1:0]  mac_fe_pkt_len,
  input  logic [NPORTS*256-1:0] mac_fe_data,
  output logic [NPORTS-1:0]     arb_mac_rdy,
  output logic                  fe_valid,
  input  logic                  fe_rdy,
  output logic [PW-1:0]         fe_port,
  output logic [11:0]           fe_pkt_len,
  output logic [255:0]          fe_data,
  output logic [15:0]           drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q;
  logic [PW-1:0]  lastGrant_q;
  logic [PW-1:0]  fePort_q;
  logic [11:0]    feLen_q;
  logic [255:0]   feData_q;

  logic           anyReq;
  logic [PW-1:0]  winner;
  logic [PW-1:0]  scanIdx;
  logic [11:0]    winLen;
  logic [255:0]   winData;
  logic           canAccept;
  logic           transfer;
  logic           lenOk;
  logic           load;

  // Round-robin scan starting just after the last granted port; walking the
  // offsets from farthest to nearest leaves the nearest requester as winner.
  always_comb begin
    anyReq  = 1'b0;
    winner  = '0;
    scanIdx = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      scanIdx = PW'((int'(lastGrant_q) + k) % NPORTS);
      if (arb_valid[scanIdx]) begin
        anyReq = 1'b1;
        winner = scanIdx;
      end
    end
  end

  // Select only the winning port's length and header; other slices are ignored.
  always_comb begin
    winLen  = '0;
    winData = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (PW'(i) == winner) begin
        winLen  = mac_fe_pkt_len[i*12 +: 12];
        winData = mac_fe_data[i*256 +: 256];
      end
    end
  end

  // The output slot is free when empty, or when the engine drains it this cycle.
  assign canAccept = (state_q == EMPTY) || fe_rdy;
  assign transfer  = anyReq && canAccept && !reset;

`ifdef FE_ARB_LEN_CHECK_EN
  assign lenOk = (winLen >= 12'd64) && (winLen <= 12'd1518);
`else
  assign lenOk = 1'b1;
`endif

  assign load = transfer && lenOk;

  // One-hot accept back to the winning MAC, combinational on fe_rdy.
  always_comb begin
    arb_mac_rdy = '0;
    if (transfer) begin
      arb_mac_rdy[winner] = 1'b1;
    end
  end

  // Output-slot FSM: load on accepted transfer, empty when drained with nothing new.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      lastGrant_q <= PW'(NPORTS - 1);
      fePort_q    <= '0;
      feLen_q     <= '0;
      feData_q    <= '0;
    end else begin
      if (transfer) begin
        lastGrant_q <= winner;
      end
      if (load) begin
        state_q  <= FULL;
        fePort_q <= winner;
        feLen_q  <= winLen;
        feData_q <= winData;
      end else if ((state_q == FULL) && fe_rdy) begin
        state_q <= EMPTY;
      end
    end
  end

  assign fe_valid   = (state_q == FULL);
  assign fe_port    = fePort_q;
  assign fe_pkt_len = feLen_q;
  assign fe_data    = feData_q;

`ifdef FE_ARB_LEN_CHECK_EN
  logic [15:0] dropCnt_q;
  logic [15:0] dropCnt_d;

  // Count accepted-but-discarded packets, saturating at all ones.
  always_comb begin
    dropCnt_d = dropCnt_q;
    if (transfer && !lenOk && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_d = dropCnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropCnt_q <= '0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign drop_cnt = dropCnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
